// File: rtl/tape_pkg.sv
// Shared definitions for the cassette-tape ADC slicer.
// Holds the default parameter values used by adc_tape_slicer and the
// encoding of the per-sample processing stage.
package tape_pkg;

  localparam int unsigned DEF_DATA_W       = 12;
  localparam int unsigned DEF_LOG2_DEPTH   = 9;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_IDLE_SAMPLES = 4800;

  // Only one sample is ever in flight, so the pipeline is tracked as a
  // single stage register rather than a chain of valid bits.
  typedef enum logic [1:0] {
    STG_IDLE = 2'd0,
    STG_S1   = 2'd1,
    STG_S2   = 2'd2,
    STG_S3   = 2'd3
  } stage_t;

endpackage

// File: rtl/tape_ring_ram.sv
// Circular sample buffer storage for the averaging window.
// Single clock, simple dual port: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, valid one cycle after raddr
module tape_ring_ram #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_tape_slicer.sv
// Cassette tape bit slicer.
// Keeps a running mean of the last 2^LOG2_DEPTH ADC samples and slices each
// new sample against that mean with hysteresis. Measures the clk count
// between bit transitions and tracks whether a tape signal is present.
// Ports:
//   clk          - clock, all logic on rising edge
//   reset        - synchronous active-high reset
//   sample       - unsigned ADC sample
//   sample_sync  - toggles once per new sample
//   hyst         - hysteresis threshold
//   invert       - inverts bit_out polarity
//   avg          - window mean
//   primed       - window has been filled once
//   bit_out      - sliced bit
//   period       - clk count between the last two transitions
//   period_valid - one-cycle strobe when period updates
//   active       - tape signal present
//   overrun      - sticky: a sample arrived while the pipeline was busy
module adc_tape_slicer
  import tape_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned LOG2_DEPTH   = DEF_LOG2_DEPTH,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned IDLE_SAMPLES = DEF_IDLE_SAMPLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_sync,
  input  logic [DATA_W-1:0] hyst,
  input  logic              invert,
  output logic [DATA_W-1:0] avg,
  output logic              primed,
  output logic              bit_out,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              active,
  output logic              overrun
);

  localparam int unsigned TOT_W  = DATA_W + LOG2_DEPTH;
  localparam int unsigned CMP_W  = DATA_W + 2;
  localparam int unsigned IDLE_W = $clog2(IDLE_SAMPLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_SAMPLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  stage_t state, state_next;

  logic                    sync_q;
  logic                    evt;
  logic                    accept;
  logic [DATA_W-1:0]       cap;
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [DATA_W-1:0]       ram_rdata;
  logic [DATA_W-1:0]       oldest;
  logic [LOG2_DEPTH:0]     fill;
  logic                    full;
  logic [TOT_W-1:0]        total;
  logic [DATA_W-1:0]       avg_now;
  logic signed [CMP_W-1:0] s_cmp, a_cmp, h_cmp, lo_cmp, hi_cmp;
  logic                    raw, raw_next;
  logic                    tr;
  logic [CNT_W-1:0]        cnt;
  logic                    seen_first;
  logic [IDLE_W-1:0]       idle_cnt;

  assign evt     = sample_sync ^ sync_q;
  assign full    = fill[LOG2_DEPTH];
  assign oldest  = full ? ram_rdata : '0;
  assign avg_now = total[TOT_W-1:LOG2_DEPTH];
  assign bit_out = raw ^ invert;

  // Stage sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STG_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      STG_IDLE: begin
        if (evt) begin
          state_next = STG_S1;
          accept     = 1'b1;
        end
      end
      STG_S1:  state_next = STG_S2;
      STG_S2:  state_next = STG_S3;
      STG_S3:  state_next = STG_IDLE;
      default: state_next = STG_IDLE;
    endcase
  end

  // S0: capture; a toggle seen while busy drops the sample
  always_ff @(posedge clk) begin
    sync_q <= sample_sync;
    if (accept) begin
      cap <= sample;
    end
    if (reset) begin
      overrun <= 1'b0;
    end else if (evt && (state != STG_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  // S1: read oldest entry and overwrite it with the new sample
  tape_ring_ram #(
    .WIDTH  (DATA_W),
    .ADDR_W (LOG2_DEPTH)
  ) u_ring (
    .clk   (clk),
    .we    (state == STG_S1),
    .waddr (wr_ptr),
    .wdata (cap),
    .raddr (wr_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (state == STG_S1) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // S2: running total; stale RAM contents are masked until the window fills
  always_ff @(posedge clk) begin
    if (reset) begin
      total  <= '0;
      fill   <= '0;
      primed <= 1'b0;
    end else if (state == STG_S2) begin
      total <= total - TOT_W'(oldest) + TOT_W'(cap);
      if (!full) begin
        fill <= fill + 1'b1;
        if (&fill[LOG2_DEPTH-1:0]) begin
          primed <= 1'b1;
        end
      end
    end
  end

  // S3: compare with two guard bits so avg +/- hyst cannot wrap
  assign s_cmp  = signed'({2'b00, cap});
  assign a_cmp  = signed'({2'b00, avg_now});
  assign h_cmp  = signed'({2'b00, hyst});
  assign lo_cmp = a_cmp - h_cmp;
  assign hi_cmp = a_cmp + h_cmp;

  always_comb begin
    raw_next = raw;
    if (primed) begin
      if (s_cmp < lo_cmp) begin
        raw_next = 1'b1;
      end else if (s_cmp > hi_cmp) begin
        raw_next = 1'b0;
      end
    end
  end

  assign tr = (state == STG_S3) && (raw_next != raw);

  always_ff @(posedge clk) begin
    if (reset) begin
      avg          <= '0;
      raw          <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      active       <= 1'b0;
      cnt          <= '0;
      seen_first   <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      period_valid <= 1'b0;
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (state == STG_S3) begin
        avg <= avg_now;
        raw <= raw_next;
        if (tr) begin
          cnt        <= '0;
          active     <= 1'b1;
          idle_cnt   <= '0;
          seen_first <= 1'b1;
          // period counts this edge too, so the loaded value is cnt + 1
          if (seen_first && (cnt != CNT_MAX)) begin
            period       <= cnt + 1'b1;
            period_valid <= 1'b1;
          end
        end else begin
          if (idle_cnt != IDLE_LIM) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (idle_cnt >= IDLE_LIM - 1'b1) begin
            active <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_tape_slicer.sv
// Self-checking bench for adc_tape_slicer with a small window
// (DATA_W=12, LOG2_DEPTH=4, CNT_W=8, IDLE_SAMPLES=8, hyst=100).
module tb_adc_tape_slicer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sample;
  logic        sample_sync;
  logic [11:0] hyst;
  logic        invert;
  logic [11:0] avg;
  logic        primed;
  logic        bit_out;
  logic [7:0]  period;
  logic        period_valid;
  logic        active;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int pv_count = 0;

  adc_tape_slicer #(
    .DATA_W       (12),
    .LOG2_DEPTH   (4),
    .CNT_W        (8),
    .IDLE_SAMPLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_sync  (sample_sync),
    .hyst         (hyst),
    .invert       (invert),
    .avg          (avg),
    .primed       (primed),
    .bit_out      (bit_out),
    .period       (period),
    .period_valid (period_valid),
    .active       (active),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: sample timestamps, a window queue and integer math.
  bit model_live = 1'b0;
  int m_win[$];
  int m_cnt, m_avg, m_period, idle;
  bit m_primed, m_raw, m_pv, m_active, m_overrun, m_seen, m_sync;
  bit pend;
  int pend_val, pend_cyc, cyc, last_tr;

  always @(posedge clk) begin
    m_pv       = 1'b0;
    model_live = 1'b1;
    if (reset) begin
      m_win.delete();
      m_cnt = 0; m_avg = 0; m_period = 0; idle = 0;
      m_primed = 0; m_raw = 0; m_active = 0; m_overrun = 0; m_seen = 0;
      pend = 0; cyc = 0; last_tr = 0;
      m_sync = sample_sync;
    end else begin
      cyc++;
      if (sample_sync != m_sync) begin
        if (pend) m_overrun = 1;
        else begin
          pend = 1; pend_cyc = cyc; pend_val = int'(sample);
        end
      end
      m_sync = sample_sync;
      if (pend && cyc == pend_cyc + 2) begin
        m_win.push_back(pend_val);
        if (m_win.size() > 16) void'(m_win.pop_front());
        m_cnt++;
        if (m_cnt >= 16) m_primed = 1;
      end
      if (pend && cyc == pend_cyc + 3) begin : s3_blk
        int sum;
        bit nr;
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_avg = sum / 16;
        nr = m_raw;
        if (m_primed) begin
          if (pend_val < m_avg - int'(hyst)) nr = 1;
          else if (pend_val > m_avg + int'(hyst)) nr = 0;
        end
        if (nr != m_raw) begin
          m_raw = nr;
          if (!m_seen) m_seen = 1;
          else if (cyc - last_tr <= 255) begin
            m_period = cyc - last_tr;
            m_pv = 1;
          end
          last_tr  = cyc;
          idle     = 0;
          m_active = 1;
        end else begin
          idle++;
          if (idle >= 8) m_active = 0;
        end
        pend = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : cmp_blk
    logic [25:0] act, exp_v;
    if (model_live) begin
      act   = {avg, primed, bit_out, period, period_valid, active, overrun};
      exp_v = {12'(m_avg), m_primed, m_raw ^ invert, 8'(m_period), m_pv, m_active, m_overrun};
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL model_cmp t=%0t got avg=%0d primed=%0b bit=%0b period=%0d pv=%0b active=%0b ovr=%0b expected avg=%0d primed=%0b bit=%0b period=%0d pv=%0b active=%0b ovr=%0b",
                 $time, avg, primed, bit_out, period, period_valid, active, overrun,
                 m_avg, m_primed, m_raw ^ invert, m_period, m_pv, m_active, m_overrun);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) pv_count = 0;
    else if (period_valid) pv_count++;
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic send(input int v, input int gap);
    sample      = 12'(v);
    sample_sync = ~sample_sync;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_avg"}, int'(avg), 0);
    chk({tag, "_primed"}, int'(primed), 0);
    chk({tag, "_bit"}, int'(bit_out), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_pv"}, int'(period_valid), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    reset = 1'b1; sample = '0; sample_sync = 1'b0; invert = 1'b0; hyst = 12'd100;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;

    // Fill window with 2048
    for (int i = 0; i < 15; i++) send(2048, 10);
    chk("fill15_primed", int'(primed), 0);
    send(2048, 10);
    chk("fill16_primed", int'(primed), 1);
    chk("fill16_avg", int'(avg), 2048);
    chk("fill16_bit", int'(bit_out), 0);
    chk("fill16_pvcount", pv_count, 0);

    // Slice with hysteresis, exact 3-clk latency
    sample = 12'd1900; sample_sync = ~sample_sync;
    repeat (3) @(negedge clk);
    chk("s1900_at2", int'(bit_out), 0);
    @(negedge clk);
    chk("s1900_at3", int'(bit_out), 1);
    repeat (6) @(negedge clk);
    send(2000, 10);
    chk("s2000_bit", int'(bit_out), 1);
    send(2200, 10);
    chk("s2200_bit", int'(bit_out), 0);
    chk("s2200_period", int'(period), 20);
    chk("s2200_pvcount", pv_count, 1);

    // Alternating groups of 8
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 8; k++) send((g % 2) ? 2300 : 1800, 10);
      chk("alt_period", int'(period), (g == 0) ? 10 : 80);
    end
    chk("alt_pvcount", pv_count, 5);
    chk("alt_active", int'(active), 1);

    // Steady signal -> inactive; then overrun
    for (int i = 0; i < 8; i++) send(2300, 10);
    chk("steady_active", int'(active), 0);
    chk("steady_avg", int'(avg), 2300);
    send(1000, 2);
    send(3000, 10);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_avg", int'(avg), 2218);
    chk("ovr_period", int'(period), 160);
    chk("ovr_active", int'(active), 1);

    // Reset during fill
    do_reset(2);
    for (int i = 0; i < 10; i++) send(2048, (i == 9) ? 1 : 10);
    do_reset(2);
    chk_all_zero("midrst");
    for (int i = 0; i < 15; i++) send(1000, 10);
    chk("refill15_primed", int'(primed), 0);
    send(1000, 10);
    chk("refill16_primed", int'(primed), 1);
    chk("refill16_avg", int'(avg), 1000);

    // Extremes: avg - hyst below zero, avg + hyst above full scale
    do_reset(2);
    for (int i = 0; i < 16; i++) send(50, 10);
    chk("low_avg", int'(avg), 50);
    send(0, 10);
    chk("low_bit", int'(bit_out), 0);
    chk("low_avg2", int'(avg), 46);
    for (int i = 0; i < 16; i++) send(4050, 10);
    send(3800, 10);
    chk("high_set_bit", int'(bit_out), 1);
    chk("high_set_avg", int'(avg), 4034);
    send(4095, 10);
    chk("high_bit", int'(bit_out), 1);
    chk("high_avg", int'(avg), 4037);
    invert = 1'b1;
    @(negedge clk);
    chk("invert_bit", int'(bit_out), 0);
    invert = 1'b0;

    // Saturated period counter: transition without strobe
    repeat (300) @(negedge clk);
    for (int i = 0; i < 16; i++) send(0, 10);
    send(4095, 10);
    chk("sat_bit", int'(bit_out), 0);
    chk("sat_pvcount", pv_count, 0);
    chk("sat_period", int'(period), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
